// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions used by the writeback stage: load encodings,
// the register-file write request type and the load-data formatter.
package wb_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    // Halfword selection uses only addr_lo[1]; unknown funct3 passes the word through.
    function automatic logic [31:0] format_load(input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] rdata);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order queue for long-latency unit responses awaiting a free writeback slot.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  wb_req_t        push_data,
    output wb_req_t        head,
    output logic           full,
    output logic           empty,
    output logic [DEPTH:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = DEPTH + 1;

    wb_req_t           mem_q [DEPTH];
    wb_req_t           mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: owns the single register-file write port, arbitrating between
// the pipeline result and queued long-latency responses, with a starvation stall.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int LU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_M_wb_en,
    input  logic [4:0]  i_M_rd_index,
    input  logic        i_M_is_load,
    input  logic [2:0]  i_M_funct3,
    input  logic [1:0]  i_M_addr_lo,
    input  logic [31:0] i_M_alu_result,
    input  logic [31:0] i_M_ld_rdata,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_rd_index,
    input  logic [31:0] i_lu_data,
    output logic        o_lu_ready,
    output logic        o_stall_req,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd_index,
    output logic [31:0] o_wb_data
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                fifo_head;
    wb_req_t                lu_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LU_FIFO_DEPTH:0] fifo_count;
    logic                   fifo_push;
    logic                   fifo_pop;

    logic                   pipe_busy;
    logic                   lu_keep;
    logic [31:0]            pipe_data;

    logic                   stall_q, stall_d;
    logic [STV_W-1:0]       starve_q, starve_d;
    logic                   wb_en_q, wb_en_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [31:0]            wb_data_q, wb_data_d;

    assign lu_req    = '{rd: i_lu_rd_index, data: i_lu_data};
    // A stall cycle turns the MEM slot into a bubble so the queue head can retire.
    assign pipe_busy = i_M_wb_en && (i_M_rd_index != '0) && !stall_q;
    // Responses to x0 are handshaken but never occupy a queue entry or write slot.
    assign lu_keep   = i_lu_valid && !fifo_full && (i_lu_rd_index != '0);
    assign pipe_data = i_M_is_load ? format_load(i_M_funct3, i_M_addr_lo, i_M_ld_rdata)
                                   : i_M_alu_result;

    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;

        if (pipe_busy) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = i_M_rd_index;
            wb_data_d = pipe_data;
            fifo_push = lu_keep;
        end else if (!fifo_empty) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = fifo_head.rd;
            wb_data_d = fifo_head.data;
            fifo_pop  = 1'b1;
            fifo_push = lu_keep;
        end else if (lu_keep) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = lu_req.rd;
            wb_data_d = lu_req.data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || (fifo_count == '0)) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end
        stall_d = (starve_d == STV_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= 1'b0;
            starve_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            stall_q   <= stall_d;
            starve_q  <= starve_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    wb_fifo #(
        .DEPTH (LU_FIFO_DEPTH)
    ) u_lu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (lu_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_lu_ready    = !fifo_full;
    assign o_stall_req   = stall_q;
    assign o_wb_en       = wb_en_q;
    assign o_wb_rd_index = wb_rd_q;
    assign o_wb_data     = wb_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic, all checked
// against a queue-based reference of the writeback arbitration rules.
module tb_wb_stage;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_M_wb_en;
    logic [4:0]  i_M_rd_index;
    logic        i_M_is_load;
    logic [2:0]  i_M_funct3;
    logic [1:0]  i_M_addr_lo;
    logic [31:0] i_M_alu_result;
    logic [31:0] i_M_ld_rdata;
    logic        i_lu_valid;
    logic [4:0]  i_lu_rd_index;
    logic [31:0] i_lu_data;
    logic        o_lu_ready;
    logic        o_stall_req;
    logic        o_wb_en;
    logic [4:0]  o_wb_rd_index;
    logic [31:0] o_wb_data;

    always #5 clk = ~clk;

    wb_stage #(
        .LU_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_M_wb_en      (i_M_wb_en),
        .i_M_rd_index   (i_M_rd_index),
        .i_M_is_load    (i_M_is_load),
        .i_M_funct3     (i_M_funct3),
        .i_M_addr_lo    (i_M_addr_lo),
        .i_M_alu_result (i_M_alu_result),
        .i_M_ld_rdata   (i_M_ld_rdata),
        .i_lu_valid     (i_lu_valid),
        .i_lu_rd_index  (i_lu_rd_index),
        .i_lu_data      (i_lu_data),
        .o_lu_ready     (o_lu_ready),
        .o_stall_req    (o_stall_req),
        .o_wb_en        (o_wb_en),
        .o_wb_rd_index  (o_wb_rd_index),
        .o_wb_data      (o_wb_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference state: pending responses in order, expected stall flag, wait length.
    logic [36:0] mq[$];
    bit          m_stall;
    int          m_waits;
    bit          m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_stall = 0;
        m_waits = 0;
        m_en    = 0;
    endtask

    // Predict the outcome of the current inputs, clock once, then compare.
    task automatic step();
        bit busy, keep, was_empty, popped;
        keep      = i_lu_valid && (mq.size() < DEPTH) && (i_lu_rd_index != 0);
        busy      = i_M_wb_en && (i_M_rd_index != 0) && !m_stall;
        was_empty = (mq.size() == 0);
        popped    = 0;
        if (busy) begin
            m_en   = 1;
            m_rd   = i_M_rd_index;
            m_data = i_M_is_load ? ref_load(i_M_funct3, i_M_addr_lo, i_M_ld_rdata)
                                 : i_M_alu_result;
            if (keep) mq.push_back({i_lu_rd_index, i_lu_data});
        end else if (!was_empty) begin
            {m_rd, m_data} = mq.pop_front();
            m_en   = 1;
            popped = 1;
            if (keep) mq.push_back({i_lu_rd_index, i_lu_data});
        end else if (keep) begin
            m_en   = 1;
            m_rd   = i_lu_rd_index;
            m_data = i_lu_data;
        end else begin
            m_en = 0;
        end
        if (popped || was_empty) m_waits = 0;
        else m_waits++;
        m_stall = (m_waits == LIMIT);

        @(posedge clk);
        #1;
        check("wb_en", o_wb_en, m_en);
        if (m_en) begin
            check("wb_rd", o_wb_rd_index, m_rd);
            check("wb_data", o_wb_data, m_data);
        end
        check("stall_req", o_stall_req, m_stall);
        check("lu_ready", o_lu_ready, mq.size() < DEPTH);
    endtask

    task automatic idle_in();
        i_M_wb_en      = 0;
        i_M_rd_index   = 0;
        i_M_is_load    = 0;
        i_M_funct3     = 0;
        i_M_addr_lo    = 0;
        i_M_alu_result = 0;
        i_M_ld_rdata   = 0;
        i_lu_valid     = 0;
        i_lu_rd_index  = 0;
        i_lu_data      = 0;
    endtask

    task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] data);
        i_M_wb_en      = 1;
        i_M_rd_index   = rd;
        i_M_is_load    = 0;
        i_M_alu_result = data;
    endtask

    task automatic lu_send(input logic [4:0] rd, input logic [31:0] data);
        i_lu_valid    = 1;
        i_lu_rd_index = rd;
        i_lu_data     = data;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_a   [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                               32'h00007F01, 32'h80FF7F01};

    initial begin
        int stalls;
        int busy_pct;

        idle_in();
        model_clear();
        #2 rst = 1;
        #1;
        check("rst_wb_en", o_wb_en, 0);
        check("rst_wb_rd", o_wb_rd_index, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_stall", o_stall_req, 0);
        check("rst_ready", o_lu_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;

        pipe_alu(5'd5, 32'h1234);
        step();
        check("alu_data", o_wb_data, 32'h0000_1234);
        pipe_alu(5'd0, 32'hABCD);
        step();
        check("rd0_no_write", o_wb_en, 0);

        for (int i = 0; i < 5; i++) begin
            idle_in();
            i_M_wb_en    = 1;
            i_M_rd_index = 5'd3;
            i_M_is_load  = 1;
            i_M_funct3   = ld_f3[i];
            i_M_addr_lo  = ld_a[i];
            i_M_ld_rdata = 32'h80FF7F01;
            step();
            check("load_fmt", o_wb_data, ld_exp[i]);
        end

        idle_in();
        lu_send(5'd7, 32'hDEAD);
        step();
        check("bypass_data", o_wb_data, 32'h0000_DEAD);
        idle_in();
        step();

        // Busy pipeline: two responses queue, the third is refused, then stalls drain them.
        stalls = 0;
        for (int k = 0; k < 25; k++) begin
            idle_in();
            pipe_alu(5'($urandom_range(1, 31)), $urandom);
            if (k < 3) lu_send(5'(k + 10), 32'h100 + k);
            if (k == 2) check("lu_ready_full", o_lu_ready, 0);
            step();
            stalls += int'(o_stall_req);
        end
        check("stall_pulses", stalls, 2);

        idle_in();
        pipe_alu(5'd4, 32'h44);
        lu_send(5'd9, 32'h9999);
        step();
        idle_in();
        step();
        check("free_slot_rd", o_wb_rd_index, 9);
        step();

        // Asynchronous reset while two responses are queued.
        pipe_alu(5'd2, 32'h22);
        lu_send(5'd10, 32'hA);
        step();
        lu_send(5'd11, 32'hB);
        step();
        #2 rst = 1;
        #1;
        check("mid_rst_wb_en", o_wb_en, 0);
        check("mid_rst_wb_rd", o_wb_rd_index, 0);
        check("mid_rst_wb_data", o_wb_data, 0);
        check("mid_rst_stall", o_stall_req, 0);
        check("mid_rst_ready", o_lu_ready, 1);
        model_clear();
        idle_in();
        @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 4; k++) step();

        for (int k = 0; k < 800; k++) begin
            busy_pct = (k < 400) ? 6 : 9;
            i_M_wb_en      = ($urandom_range(0, 9) < busy_pct);
            i_M_rd_index   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            i_M_is_load    = $urandom_range(0, 1) == 1;
            i_M_funct3     = 3'($urandom_range(0, 7));
            i_M_addr_lo    = 2'($urandom_range(0, 3));
            i_M_alu_result = $urandom;
            i_M_ld_rdata   = $urandom;
            i_lu_valid     = ($urandom_range(0, 9) < 4);
            i_lu_rd_index  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            i_lu_data      = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage driving the register file's single write port. It registers the MEM-stage result, formats load data (byte/half extraction with sign/zero extension), and merges responses from the long-latency unit (mul/div) through a small FIFO. Those responses are written only in cycles the pipeline leaves free. A starvation counter requests a one-cycle pipeline stall so queued responses always retire.

## Interface
- LU_FIFO_DEPTH, default 2: long-latency response FIFO entries (power of two, ≥2).
- STARVE_LIMIT, default 8: cycles a FIFO head may wait before a stall is requested (≥1).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_M_wb_en  in  1  pipeline instruction writes rd.
- i_M_rd_index  in  5  pipeline destination.
- i_M_is_load  in  1  select formatted load data instead of i_M_alu_result.
- i_M_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_M_addr_lo  in  2  effective address bits [1:0].
- i_M_alu_result  in  32  non-load result.
- i_M_ld_rdata  in  32  raw aligned memory word.
- i_lu_valid  in  1  long-latency response valid.
- i_lu_rd_index  in  5  response destination.
- i_lu_data  in  32  response data.
- o_lu_ready  out  1  FIFO can accept (= !full).
- o_stall_req  out  1  hazard unit must freeze IF..MEM next cycle.
- o_wb_en  out  1  register-file write enable.
- o_wb_rd_index  out  5  register-file write index.
- o_wb_data  out  32  register-file write data.

## Operation
- Pipeline slot is "busy" when i_M_wb_en=1, i_M_rd_index≠0 and o_stall_req=0. Otherwise the slot is free.
- Busy: o_wb_* <= pipeline result. Free and FIFO non-empty: o_wb_* <= FIFO head, then pop. Free and FIFO empty with i_lu_valid=1: response bypasses the FIFO straight to o_wb_*. This counts as enqueue and dequeue in the same cycle. Otherwise o_wb_en <= 0.
- o_wb_en is never asserted with o_wb_rd_index=0. LU responses to rd 0 are accepted and dropped without occupying a write slot.
- Load formatting: LB/LBU select the byte at addr_lo. LH/LHU select the half at addr_lo[1], ignoring addr_lo[0]. LW uses the full word and ignores addr_lo. LB/LH sign-extend; LBU/LHU zero-extend. Any other funct3 value yields the raw word.
- FIFO: enqueue on i_lu_valid && o_lu_ready; in-order; occupancy count is LU_FIFO_DEPTH+1 bits wide. Pointers wrap modulo depth. Simultaneous push and pop with the FIFO full cannot happen, since ready is low.
- Starvation: the counter increments each cycle the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty. When the count reaches STARVE_LIMIT, o_stall_req <= 1. While o_stall_req=1, i_M_* is ignored as a bubble, the head pops, and o_stall_req <= 0 the next cycle. Upstream re-presents the frozen instruction.
- WAW ordering between in-flight LU destinations and pipeline destinations is guaranteed by the scoreboard. This block does not check it.

## Timing
- Reset: o_wb_en=0, o_wb_rd_index=0, o_wb_data=0, o_stall_req=0, o_lu_ready=1. FIFO is emptied and the counter cleared. Rst mid-operation drops queued responses.
- Pipeline result appears on o_wb_* one cycle after it is presented. LU response appears one cycle after the handshake when bypassing. Otherwise it appears in the first free slot.
- o_lu_ready derives from registered occupancy only; there is no combinational path from i_lu_valid.
- o_stall_req is registered and lasts exactly one cycle per starvation event.
- The register file forwards o_wb_* combinationally, so all o_wb_* are flop outputs.

## Structure
- Shared CPU package: load funct3 encodings (LB, LH, LW, LBU, LHU) and a wb_req_t struct {rd[4:0], data[31:0]}.
- One sub-module: wb_fifo (parameterised depth, push/pop, full/empty, head, occupancy). Load formatter and arbiter stay inline.

## Test plan
- Reset, then pipeline ALU write rd=5, data=0x1234 → next cycle o_wb_en=1, rd=5, data=0x00001234. A later write to rd=0 gives o_wb_en=0.
- Load with rdata=0x80FF7F01: LB addr_lo=3 → 0xFFFFFF80; LBU addr_lo=1 → 0x0000007F; LH addr_lo=2 → 0xFFFF80FF; LHU addr_lo=0 → 0x00007F01; LW → 0x80FF7F01.
- Idle pipeline with LU response rd=7, 0xDEAD → bypass, o_wb rd=7, data=0xDEAD next cycle, and the FIFO stays empty.
- Pipeline busy every cycle while LU sends 3 responses → two accepted, o_lu_ready=0 on the third. After 8 waiting cycles o_stall_req=1 for one cycle, the first response is written, and the pipeline instruction is ignored that cycle.
- Pipeline busy, LU response rd=9, then a free cycle → rd=9 written in the free slot, and the starvation counter clears.
- Assert rst with 2 entries queued → all outputs reset, o_lu_ready=1, and no stale write afterwards.
